// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Responder end of the datapath load/store interface. Accepts one request at
//   a time, runs it against an internal word-organised RAM after a
//   programmable number of wait states, and returns extended load data with a
//   one-cycle Ready pulse. Rejected requests still walk all FSM states and
//   complete with Error_o.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   Mem_Read_i    load request strobe
//   Mem_Write_i   store request strobe
//   Address_i     byte address
//   Write_Data_i  store data (low bytes used for SB/SH)
//   Funct3_i      access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   Read_Data_o   extended load data, valid while Ready_o=1, else 0
//   Ready_o       one-cycle completion pulse
//   Busy_o        combinational stall request to the datapath
//   Error_o       pulses with Ready_o when the request was rejected
// ---------------------------------------------------------------------------
module data_memory_responder #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  input  logic [2:0]  Funct3_i,
  output logic [31:0] Read_Data_o,
  output logic        Ready_o,
  output logic        Busy_o,
  output logic        Error_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned CW = 4;

  // Last value of the wait counter before moving on to ACCESS.
  localparam logic [CW-1:0] WAIT_LAST = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM and request registers
  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [DW-1:0] offset_q, offset_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          is_rd_q,  is_rd_d;
  logic          is_wr_q,  is_wr_d;

  // Registered response
  logic [DW-1:0] rdata_q,  rdata_d;
  logic          ready_q,  ready_d;
  logic          error_q,  error_d;

  // RAM (contents survive reset)
  logic [DW-1:0] mem_q [MEMORY_DEPTH];

  logic [AW-1:0] mem_idx;
  logic [1:0]    lane;
  logic [DW-1:0] mem_word;
  logic          range_err;
  logic          align_err;
  logic          funct_err;
  logic          req_err;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;
  logic [3:0]    st_be;
  logic [DW-1:0] st_data;
  logic          mem_we;

  assign mem_idx  = offset_q[AW+1:2];
  assign lane     = offset_q[1:0];
  assign mem_word = mem_q[mem_idx];

  // Request validation on the latched request; an address below BASE_ADDR
  // wraps to a huge offset and is caught by the range check.
  always_comb begin
    range_err = (offset_q[31:2] >= 30'(MEMORY_DEPTH));
    align_err = 1'b0;
    funct_err = 1'b0;
    case (funct3_q)
      F3_H, F3_HU: align_err = lane[0];
      F3_W:        align_err = (lane != 2'b00);
      default:     align_err = 1'b0;
    endcase
    if (is_wr_q) begin
      funct_err = !((funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W));
    end else begin
      funct_err = !((funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W) ||
                    (funct3_q == F3_BU) || (funct3_q == F3_HU));
    end
    req_err = range_err || align_err || funct_err || (is_rd_q && is_wr_q);
  end

  // Load lane selection and extension
  always_comb begin
    ld_byte = 8'(mem_word >> {lane, 3'b000});
    ld_half = 16'(mem_word >> {lane[1], 4'b0000});
    case (funct3_q)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = mem_word;
      F3_BU:   ld_data = {24'h00_0000, ld_byte};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = '0;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata_q;
    case (funct3_q)
      F3_B: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        st_be   = 4'b0011 << lane;
        st_data = {2{wdata_q[15:0]}};
      end
      F3_W: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = wdata_q;
      end
    endcase
  end

  // Next-state and response logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    is_rd_d  = is_rd_q;
    is_wr_d  = is_wr_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Mem_Read_i || Mem_Write_i) begin
          offset_d = Address_i - BASE_ADDR;
          wdata_d  = Write_Data_i;
          funct3_d = Funct3_i;
          is_rd_d  = Mem_Read_i;
          is_wr_d  = Mem_Write_i;
          cnt_d    = '0;
          state_d  = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACCESS: begin
        // The RAM access and the response capture share this edge.
        state_d = ST_DONE;
        ready_d = 1'b1;
        error_d = req_err;
        mem_we  = is_wr_q && !req_err;
        if (is_rd_q && !req_err) begin
          rdata_d = ld_data;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      is_rd_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      is_rd_q  <= is_rd_d;
      is_wr_q  <= is_wr_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  // Byte-enable RAM write; mem_we is only raised in ACCESS, so a reset that
  // lands before ACCESS never commits the store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign Read_Data_o = rdata_q;
  assign Ready_o     = ready_q;
  assign Error_o     = error_q;
  assign Busy_o      = ((state_q == ST_IDLE) && (Mem_Read_i || Mem_Write_i)) ||
                       (state_q == ST_WAIT) || (state_q == ST_ACCESS);

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//   Directed bench: a table of load/store requests against a WAIT_STATES=1
//   instance, plus hand-written sequences for reset mid-request and
//   back-to-back requests on a WAIT_STATES=0 instance.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // WAIT_STATES=1 instance
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        ready, busy, err;
  // WAIT_STATES=0 instance
  logic        rd0, wr0;
  logic [31:0] addr0, wdata0;
  logic [2:0]  f30;
  logic [31:0] rdata0;
  logic        ready0, busy0, err0;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(.MEMORY_DEPTH(64), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(rst_n),
    .Mem_Read_i(rd), .Mem_Write_i(wr), .Address_i(addr), .Write_Data_i(wdata), .Funct3_i(f3),
    .Read_Data_o(rdata), .Ready_o(ready), .Busy_o(busy), .Error_o(err)
  );

  data_memory_responder #(.MEMORY_DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .Mem_Read_i(rd0), .Mem_Write_i(wr0), .Address_i(addr0), .Write_Data_i(wdata0), .Funct3_i(f30),
    .Read_Data_o(rdata0), .Ready_o(ready0), .Busy_o(busy0), .Error_o(err0)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 instance. Inputs are scrambled after
  // the accept edge to show that the request was latched.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, output logic [31:0] rd_o, output logic er_o,
                        output int lat, output logic hs_ok);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; f3 = f;
    #1;
    hs_ok = busy;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFF; wdata = ~d; f3 = 3'b111;
    lat = 0; rd_o = '0; er_o = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c; rd_o = rdata; er_o = err;
        hs_ok = hs_ok && !busy;
        break;
      end
      hs_ok = hs_ok && busy;
    end
    @(negedge clk);
    hs_ok = hs_ok && !ready && !err && (rdata == 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] got_d;
    logic        got_e;
    int          got_lat;
    logic        got_hs;
    logic [5:0]  exp_busy0;
    logic [5:0]  exp_ready0;

    rst_n = 1'b0;
    rd = 0; wr = 0; addr = '0; wdata = '0; f3 = '0;
    rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0; f30 = '0;

    //            name             rd wr addr          wdata          f3      exp_data       exp_err
    vecs.push_back('{"sw_beef",    0, 1, BASE + 4,    32'hDEADBEEF, 3'b010, 32'h0,         1'b0});
    vecs.push_back('{"lw_beef",    1, 0, BASE + 4,    32'h0,        3'b010, 32'hDEADBEEF,  1'b0});
    vecs.push_back('{"sw_w0",      0, 1, BASE,        32'h80817F80, 3'b010, 32'h0,         1'b0});
    vecs.push_back('{"lb_0",       1, 0, BASE,        32'h0,        3'b000, 32'hFFFFFF80,  1'b0});
    vecs.push_back('{"lbu_0",      1, 0, BASE,        32'h0,        3'b100, 32'h00000080,  1'b0});
    vecs.push_back('{"lh_2",       1, 0, BASE + 2,    32'h0,        3'b001, 32'hFFFF8081,  1'b0});
    vecs.push_back('{"lhu_2",      1, 0, BASE + 2,    32'h0,        3'b101, 32'h00008081,  1'b0});
    vecs.push_back('{"lb_1",       1, 0, BASE + 1,    32'h0,        3'b000, 32'h0000007F,  1'b0});
    vecs.push_back('{"lh_0",       1, 0, BASE,        32'h0,        3'b001, 32'h00007F80,  1'b0});
    vecs.push_back('{"lh_beef",    1, 0, BASE + 6,    32'h0,        3'b001, 32'hFFFFDEAD,  1'b0});
    vecs.push_back('{"lbu_7",      1, 0, BASE + 7,    32'h0,        3'b100, 32'h000000DE,  1'b0});
    vecs.push_back('{"sw_w2",      0, 1, BASE + 8,    32'h11223344, 3'b010, 32'h0,         1'b0});
    vecs.push_back('{"sb_9",       0, 1, BASE + 9,    32'hFFFFFF55, 3'b000, 32'h0,         1'b0});
    vecs.push_back('{"lw_sb",      1, 0, BASE + 8,    32'h0,        3'b010, 32'h11225544,  1'b0});
    vecs.push_back('{"sh_a",       0, 1, BASE + 10,   32'h1234AAAA, 3'b001, 32'h0,         1'b0});
    vecs.push_back('{"lw_sh",      1, 0, BASE + 8,    32'h0,        3'b010, 32'hAAAA5544,  1'b0});
    vecs.push_back('{"lw_mis",     1, 0, BASE + 2,    32'h0,        3'b010, 32'h0,         1'b1});
    vecs.push_back('{"sh_mis",     0, 1, BASE + 9,    32'h0000FFFF, 3'b001, 32'h0,         1'b1});
    vecs.push_back('{"lw_oor",     1, 0, BASE + 256,  32'h0,        3'b010, 32'h0,         1'b1});
    vecs.push_back('{"lw_below",   1, 0, 32'h1000FFFC, 32'h0,       3'b010, 32'h0,         1'b1});
    vecs.push_back('{"lw_keep2",   1, 0, BASE + 8,    32'h0,        3'b010, 32'hAAAA5544,  1'b0});
    vecs.push_back('{"sbu_bad",    0, 1, BASE,        32'h0,        3'b100, 32'h0,         1'b1});
    vecs.push_back('{"both",       1, 1, BASE,        32'h0,        3'b010, 32'h0,         1'b1});
    vecs.push_back('{"ld_f3_011",  1, 0, BASE,        32'h0,        3'b011, 32'h0,         1'b1});
    vecs.push_back('{"lw_keep0",   1, 0, BASE,        32'h0,        3'b010, 32'h80817F80,  1'b0});
    vecs.push_back('{"sw_last",    0, 1, BASE + 252,  32'h0BADF00D, 3'b010, 32'h0,         1'b0});
    vecs.push_back('{"lw_last",    1, 0, BASE + 252,  32'h0,        3'b010, 32'h0BADF00D,  1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_ready", 32'(ready), 32'h0);
    check32("reset_busy",  32'(busy),  32'h0);
    check32("reset_error", 32'(err),   32'h0);
    rst_n = 1'b1;

    // Table-driven requests on the WAIT_STATES=1 instance
    foreach (vecs[i]) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
             got_d, got_e, got_lat, got_hs);
      check32({vecs[i].name, "_data"},    got_d,          vecs[i].exp_data);
      check32({vecs[i].name, "_error"},   32'(got_e),     32'(vecs[i].exp_err));
      check32({vecs[i].name, "_latency"}, 32'(got_lat),   32'd3);
      check32({vecs[i].name, "_hshake"},  32'(got_hs),    32'd1);
    end

    // Reset in the middle of a store's WAIT state: store must not commit
    @(negedge clk);
    wr = 1'b1; addr = BASE + 4; wdata = 32'h12345678; f3 = 3'b010;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    check32("midwait_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check32("midwait_ready", 32'(ready), 32'h0);
    check32("midwait_busy",  32'(busy),  32'h0);
    check32("midwait_rdata", rdata,      32'h0);
    check32("midwait_error", 32'(err),   32'h0);
    repeat (3) @(negedge clk);
    check32("midwait_ready_held", 32'(ready), 32'h0);
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, BASE + 4, 32'h0, 3'b010, got_d, got_e, got_lat, got_hs);
    check32("midwait_lw_data",    got_d,        32'hDEADBEEF);
    check32("midwait_lw_error",   32'(got_e),   32'h0);
    check32("midwait_lw_latency", 32'(got_lat), 32'd3);

    // WAIT_STATES=0: store a word, then back-to-back loads with the strobe held
    @(negedge clk);
    wr0 = 1'b1; addr0 = BASE + 12; wdata0 = 32'hCAFEF00D; f30 = 3'b010;
    @(posedge clk);
    #1;
    wr0 = 1'b0;
    repeat (3) @(negedge clk);

    exp_busy0  = 6'b011011;
    exp_ready0 = 6'b100100;
    @(negedge clk);
    rd0 = 1'b1; addr0 = BASE + 12; f30 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      #1;
      check32($sformatf("b2b_busy_%0d", i),  32'(busy0),  32'(exp_busy0[i]));
      check32($sformatf("b2b_ready_%0d", i), 32'(ready0), 32'(exp_ready0[i]));
      if (exp_ready0[i]) begin
        check32($sformatf("b2b_data_%0d", i),  rdata0,      32'hCAFEF00D);
        check32($sformatf("b2b_error_%0d", i), 32'(err0),   32'h0);
      end
      @(negedge clk);
    end
    rd0 = 1'b0;
    #1;
    check32("b2b_idle_busy", 32'(busy0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
